// File: rtl/pe_array_job_sched.sv
// Job sequencer for the 8x8 PE cluster: latches one A/B operand set, clears the
// cluster, feeds diagonally skewed operand lanes, then waits for all PE done flags.
module pe_array_job_sched #(
  parameter int ROWS    = 8,
  parameter int DW      = 16,
  parameter int KMAX    = 8,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     start,
  input  logic [3:0]               k_len,
  input  logic [ROWS*KMAX*DW-1:0]  a_mat,
  input  logic [ROWS*KMAX*DW-1:0]  b_mat,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     cl_rst_n,
  output logic [ROWS*DW-1:0]       cl_act,
  output logic [ROWS*DW-1:0]       cl_wgt,
  output logic [ROWS-1:0]          cl_lane_done,
  input  logic [ROWS*ROWS-1:0]     cl_out_done
);

  localparam int TW = $clog2(KMAX + ROWS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             clr_q, clr_d;
  logic [TW-1:0]             t_q, t_d;
  logic [WW-1:0]             wd_q, wd_d;
  logic [3:0]                k_q;
  logic [ROWS*KMAX*DW-1:0]   a_q, b_q;
  logic                      load_op, err_ev;

  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                      cl_rst_n_q, cl_rst_n_d;
  logic [ROWS*DW-1:0]        act_q, act_d, wgt_q, wgt_d;
  logic [ROWS-1:0]           lane_done_q, lane_done_d;

  logic                      k_ok;
  logic [TW-1:0]             t_last;

  assign k_ok   = (k_len != 4'd0) && (int'(k_len) <= KMAX);
  assign t_last = TW'(int'(k_q) + ROWS - 2);

  // State and counters; en low freezes everything, stretching any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_q   <= '0;
      t_q     <= '0;
      wd_q    <= '0;
      k_q     <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      clr_q   <= clr_d;
      t_q     <= t_d;
      wd_q    <= wd_d;
      if (load_op) k_q <= k_len;
    end
  end

  // NOTE: the operand store has no reset; it is only read during FEED, after a load.
  always_ff @(posedge clk) begin
    if (en && load_op) begin
      a_q <= a_mat;
      b_q <= b_mat;
    end
  end

  always_comb begin : next_state
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    clr_d   = clr_q;
    t_d     = t_q;
    wd_d    = wd_q;
    load_op = 1'b0;
    err_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_ok) begin
            load_op = 1'b1;
            clr_d   = '0;
            state_d = CLEAR;
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (clr_q == CW'(CLR_CYC - 1)) begin
          state_d = FEED;
          t_d     = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      FEED: begin
        if (t_q == t_last) begin
          state_d = DRAIN;
          wd_d    = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        wd_d = wd_q + 1'b1;
        // All-ones takes priority over a watchdog expiry in the same cycle.
        if (&cl_out_done) begin
          state_d = DONE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_ev  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered pins track the phase.
  always_comb begin : output_logic
    int d;
    d           = 0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    err_d       = err_ev;
    cl_rst_n_d  = (state_d != CLEAR);
    act_d       = '0;
    wgt_d       = '0;
    lane_done_d = '0;
    if (state_d == DRAIN || state_d == DONE) begin
      lane_done_d = '1;
    end else if (state_d == FEED) begin
      for (int i = 0; i < ROWS; i++) begin
        d = int'(t_d) - i;
        lane_done_d[i] = (int'(t_d) >= i + int'(k_q));
        if (d >= 0 && d < int'(k_q)) begin
          act_d[i*DW +: DW] = a_q[(i*KMAX + d)*DW +: DW];
          wgt_d[i*DW +: DW] = b_q[(i*KMAX + d)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cl_rst_n_q  <= 1'b0;
      act_q       <= '0;
      wgt_q       <= '0;
      lane_done_q <= '0;
    end else if (en) begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cl_rst_n_q  <= cl_rst_n_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      lane_done_q <= lane_done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cl_rst_n     = cl_rst_n_q;
  assign cl_act       = act_q;
  assign cl_wgt       = wgt_q;
  assign cl_lane_done = lane_done_q;

endmodule

// File: tb/tb_pe_array_job_sched.sv
// Self-checking bench for pe_array_job_sched: per-cycle comparison of all outputs
// against a job-level model built from the operand arrays and phase lengths.
module tb_pe_array_job_sched;

  localparam int ROWS    = 8;
  localparam int DW      = 16;
  localparam int KMAX    = 8;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 255;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    en = 1'b1;
  logic                    start = 1'b0;
  logic [3:0]              k_len = '0;
  logic [ROWS*KMAX*DW-1:0] a_mat = '0;
  logic [ROWS*KMAX*DW-1:0] b_mat = '0;
  logic                    busy, done, err, cl_rst_n;
  logic [ROWS*DW-1:0]      cl_act, cl_wgt;
  logic [ROWS-1:0]         cl_lane_done;
  logic [ROWS*ROWS-1:0]    cl_out_done = '0;

  pe_array_job_sched #(
    .ROWS(ROWS), .DW(DW), .KMAX(KMAX), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .start        (start),
    .k_len        (k_len),
    .a_mat        (a_mat),
    .b_mat        (b_mat),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cl_rst_n     (cl_rst_n),
    .cl_act       (cl_act),
    .cl_wgt       (cl_wgt),
    .cl_lane_done (cl_lane_done),
    .cl_out_done  (cl_out_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               busy;
    logic               done;
    logic               err;
    logic               rst_n;
    logic [ROWS-1:0]    lane_done;
    logic [ROWS*DW-1:0] act;
    logic [ROWS*DW-1:0] wgt;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] a_arr [ROWS][KMAX];
  logic [DW-1:0] b_arr [ROWS][KMAX];

  function automatic obs_t dut_obs();
    return obs_t'({busy, done, err, cl_rst_n, cl_lane_done, cl_act, cl_wgt});
  endfunction

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.rst_n = 1'b1;
    return e;
  endfunction

  // Expected pins at feed step t: lane i carries element t-i of row/column i.
  function automatic obs_t feed_exp(int t, int k);
    obs_t e = '0;
    e.busy  = 1'b1;
    e.rst_n = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      int kk = t - i;
      if (kk >= 0 && kk < k) begin
        e.act[i*DW +: DW] = a_arr[i][kk];
        e.wgt[i*DW +: DW] = b_arr[i][kk];
      end
      e.lane_done[i] = (t >= i + k);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_operands();
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_mat[(i*KMAX + k)*DW +: DW] = a_arr[i][k];
        b_mat[(i*KMAX + k)*DW +: DW] = b_arr[i][k];
      end
  endtask

  task automatic random_operands();
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_arr[i][k] = DW'($urandom);
        b_arr[i][k] = DW'($urandom);
      end
    pack_operands();
  endtask

  task automatic scramble_inputs();
    for (int w = 0; w < ROWS*KMAX*DW/32; w++) begin
      a_mat[w*32 +: 32] = $urandom;
      b_mat[w*32 +: 32] = $urandom;
    end
  endtask

  // Runs one job from start to the first idle cycle, comparing every cycle.
  task automatic run_job(input int k, input int drain_at, input logic [63:0] partial,
                         input int stall_t, input int abort_t);
    obs_t e, got;
    int   done_c;
    bit   exp_err;
    pack_operands();
    start = 1'b1;
    k_len = 4'(k);
    step();
    start = 1'b0;
    scramble_inputs();
    for (int c = 0; c < CLR_CYC; c++) begin
      e = '0;
      e.busy = 1'b1;
      got = dut_obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL clear c=%0d got %h exp %h", c, got, e);
      end
      step();
    end
    for (int t = 0; t <= k + ROWS - 2; t++) begin
      e = feed_exp(t, k);
      got = dut_obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL feed k=%0d t=%0d got %h exp %h", k, t, got, e);
      end
      if (t == stall_t) begin
        en = 1'b0;
        repeat (5) begin
          step();
          got = dut_obs();
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL stall t=%0d got %h exp %h", t, got, e);
          end
        end
        en = 1'b1;
      end
      if (t == abort_t) begin
        #2 rst_n = 1'b0;
        #1;
        got = dut_obs();
        checks++;
        if (got !== obs_t'('0)) begin
          errors++;
          $display("FAIL abort_async got %h exp 0", got);
        end
        repeat (3) begin
          step();
          got = dut_obs();
          checks++;
          if (got !== obs_t'('0)) begin
            errors++;
            $display("FAIL abort_hold got %h exp 0", got);
          end
        end
        rst_n = 1'b1;
        return;
      end
      step();
    end
    exp_err = (drain_at > TIMEOUT - 1);
    done_c  = exp_err ? TIMEOUT : drain_at + 1;
    for (int n = 0; n <= done_c; n++) begin
      e = '0;
      e.busy      = 1'b1;
      e.rst_n     = 1'b1;
      e.lane_done = '1;
      if (n == done_c) begin
        e.done = 1'b1;
        e.err  = exp_err;
      end
      got = dut_obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL drain n=%0d got %h exp %h", n, got, e);
      end
      cl_out_done = (n >= drain_at) ? '1 : partial;
      if (n < done_c) step();
    end
    cl_out_done = '0;
    step();
    got = dut_obs();
    checks++;
    if (got !== idle_exp()) begin
      errors++;
      $display("FAIL post_done got %h exp %h", got, idle_exp());
    end
  endtask

  function automatic logic [63:0] not_all_ones();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v[$urandom_range(63)] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    obs_t got;
    #1 rst_n = 1'b0;
    #2;
    for (int c = 0; c < 3; c++) begin
      got = dut_obs();
      checks++;
      if (got !== obs_t'('0)) begin
        errors++;
        $display("FAIL reset c=%0d got %h exp 0", c, got);
      end
      step();
    end
    rst_n = 1'b1;
    step();
    got = dut_obs();
    checks++;
    if (got !== idle_exp()) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h", got, idle_exp());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_arr[i][k] = DW'(16*i + k);
        b_arr[i][k] = DW'(16'h100 + 16*i + k);
      end
    run_job(4, 3, 64'h0, -1, -1);
  endtask

  task automatic test_illegal();
    int bad [3] = '{0, 9, 15};
    obs_t e, got;
    foreach (bad[j]) begin
      start = 1'b1;
      k_len = 4'(bad[j]);
      step();
      start = 1'b0;
      e = idle_exp();
      e.err = 1'b1;
      got = dut_obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL illegal k=%0d got %h exp %h", bad[j], got, e);
      end
      step();
      got = dut_obs();
      checks++;
      if (got !== idle_exp()) begin
        errors++;
        $display("FAIL illegal_after k=%0d got %h exp %h", bad[j], got, idle_exp());
      end
    end
  endtask

  task automatic test_back_to_back();
    int job_len = CLR_CYC + (KMAX + ROWS - 1) + 2;
    int pos;
    logic [1:0] exp_bd, got_bd;
    random_operands();
    cl_out_done = '1;
    k_len = 4'(KMAX);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      pos    = (c - 1) % (job_len + 1);
      exp_bd = {pos < job_len, pos == job_len - 1};
      got_bd = {busy, done};
      checks++;
      if (got_bd !== exp_bd) begin
        errors++;
        $display("FAIL b2b c=%0d busy_done got %b exp %b", c, got_bd, exp_bd);
      end
    end
    start = 1'b0;
    cl_out_done = '0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end busy got %b exp 0", busy);
    end
  endtask

  task automatic test_timeout();
    random_operands();
    run_job(5, 1 << 20, 64'h7FFF_FFFF_FFFF_FFFF, -1, -1);
  endtask

  task automatic test_en_stall();
    random_operands();
    run_job(6, 2, not_all_ones(), 2, -1);
  endtask

  task automatic test_abort();
    random_operands();
    run_job(KMAX, 0, 64'h0, -1, 5);
    random_operands();
    run_job(3, 1, not_all_ones(), -1, -1);
  endtask

  task automatic test_random();
    repeat (6) begin
      random_operands();
      run_job($urandom_range(1, KMAX), $urandom_range(0, 6), not_all_ones(), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_en_stall();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
